// File: rtl/seg7_scan_mux.sv
// Multiplexed driver for an N-digit common-anode 7-segment display.
// Double-buffered digit data, per-digit blank/blink, leading-zero suppression, optional hex glyphs.
module seg7_scan_mux #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned HEX_MODE     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      lz_suppress,
    input  logic                      load,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int unsigned DIG_W = 4 * NUM_DIGITS;
    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic [DIG_W-1:0]      digits;
        logic [NUM_DIGITS-1:0] blank;
        logic [NUM_DIGITS-1:0] blink;
    } frame_t;

    frame_t                shadow_q;
    frame_t                active_q;
    frame_t                load_data_c;
    logic                  pending_q;
    logic [DIV_W-1:0]      div_q;
    logic [IDX_W-1:0]      idx_q;
    logic [BLK_W-1:0]      blk_cnt_q;
    logic                  phase_q;
    logic                  div_tc_c;
    logic                  fb_c;
    logic [NUM_DIGITS-1:0] lz_dark_c;
    logic                  zeros_above_c;
    logic                  dark_c;
    logic [3:0]            code_c;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] glyph;
        glyph = 7'h3F;
        case (code)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = (HEX_MODE != 0) ? 7'h08 : 7'h3F;
            4'hB: glyph = (HEX_MODE != 0) ? 7'h03 : 7'h3F;
            4'hC: glyph = (HEX_MODE != 0) ? 7'h46 : 7'h3F;
            4'hD: glyph = (HEX_MODE != 0) ? 7'h21 : 7'h3F;
            4'hE: glyph = (HEX_MODE != 0) ? 7'h06 : 7'h3F;
            4'hF: glyph = (HEX_MODE != 0) ? 7'h0E : 7'h3F;
            default: glyph = 7'h3F;
        endcase
        return glyph;
    endfunction

    assign load_data_c = '{digits: digits_in, blank: blank_mask, blink: blink_mask};
    assign div_tc_c    = (div_q == DIV_W'(REFRESH_DIV - 1));
    assign fb_c        = div_tc_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // Refresh divider and scan index; the index wrap is the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_tc_c) begin
            div_q <= '0;
            idx_q <= fb_c ? '0 : idx_q + IDX_W'(1);
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Blink phase toggles every BLINK_FRAMES frames; phase 0 is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else if (fb_c) begin
            if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blk_cnt_q <= '0;
                phase_q   <= ~phase_q;
            end else begin
                blk_cnt_q <= blk_cnt_q + BLK_W'(1);
            end
        end
    end

    // Shadow/active buffer: a load coinciding with the boundary bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (load) begin
                shadow_q <= load_data_c;
            end
            if (fb_c) begin
                if (load) begin
                    active_q <= load_data_c;
                end else if (pending_q) begin
                    active_q <= shadow_q;
                end
                pending_q <= 1'b0;
            end else if (load) begin
                pending_q <= 1'b1;
            end
        end
    end

    // A digit is zero-suppressed when it and every digit to its left are zero.
    always_comb begin
        lz_dark_c     = '0;
        zeros_above_c = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            zeros_above_c = zeros_above_c && (active_q.digits[4*d +: 4] == 4'd0);
            lz_dark_c[d]  = lz_suppress && zeros_above_c;
        end
    end

    always_comb begin
        code_c = active_q.digits[4*idx_q +: 4];
        dark_c = active_q.blank[idx_q]
               | (active_q.blink[idx_q] & phase_q)
               | lz_dark_c[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= 7'h7F;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg        <= dark_c ? 7'h7F : decode(code_c);
            an         <= ~(NUM_DIGITS'(1) << idx_q);
            frame_tick <= fb_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: directed scenarios plus random loads, checked against a
// frame-level model derived from the cycle count since reset release.
module tb_seg7_scan_mux;

    localparam int R  = 4;
    localparam int BF = 2;
    localparam int N  = 4;
    localparam int FR = R * N;

    typedef struct {
        int         cyc;
        logic [15:0] d;
        logic [3:0]  bl;
        logic [3:0]  bk;
    } load_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic        lz_suppress;
    logic        load;
    logic [6:0]  seg_hex, seg_dec;
    logic [3:0]  an_hex, an_dec;
    logic        ft_hex, ft_dec;

    int    n_cmp;
    int    n_err;
    int    c;
    load_t loads[$];

    seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF), .HEX_MODE(1)) dut_hex (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .lz_suppress(lz_suppress), .load(load),
        .seg(seg_hex), .an(an_hex), .frame_tick(ft_hex)
    );

    seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF), .HEX_MODE(0)) dut_dec (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .lz_suppress(lz_suppress), .load(load),
        .seg(seg_dec), .an(an_dec), .frame_tick(ft_dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input int v, input bit hex);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            10: return hex ? 7'h08 : 7'h3F;
            11: return hex ? 7'h03 : 7'h3F;
            12: return hex ? 7'h46 : 7'h3F;
            13: return hex ? 7'h21 : 7'h3F;
            14: return hex ? 7'h06 : 7'h3F;
            default: return hex ? 7'h0E : 7'h3F;
        endcase
    endfunction

    // Output after the edge that ends cycle cy: digit (cy/R)%N of frame cy/FR,
    // showing the last load made no later than the final cycle of the previous frame.
    function automatic void model(input int cy, input bit hex, input bit lz,
                                  output logic [6:0] s, output logic [3:0] a, output logic ft);
        int          idx;
        int          f;
        bit          phase;
        bit          dark;
        logic [15:0] d;
        logic [3:0]  bl;
        logic [3:0]  bk;
        idx   = (cy / R) % N;
        f     = cy / FR;
        phase = ((f / BF) % 2) == 1;
        d = '0; bl = '0; bk = '0;
        foreach (loads[i]) begin
            if (loads[i].cyc <= f * FR - 1) begin
                d  = loads[i].d;
                bl = loads[i].bl;
                bk = loads[i].bk;
            end
        end
        dark = bl[idx] || (bk[idx] && phase) || (lz && idx > 0 && (d >> (4 * idx)) == 16'd0);
        s  = dark ? 7'h7F : ref_glyph(int'(d[4*idx +: 4]), hex);
        a  = ~(4'b0001 << idx);
        ft = (cy % FR) == FR - 1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] bl,
                        input logic [3:0] bk, input bit lz);
        logic [6:0] s;
        logic [3:0] a;
        logic       ft;
        load_t      rec;
        digits_in   = d;
        blank_mask  = bl;
        blink_mask  = bk;
        lz_suppress = lz;
        load        = ld;
        if (ld) begin
            rec.cyc = c; rec.d = d; rec.bl = bl; rec.bk = bk;
            loads.push_back(rec);
        end
        @(posedge clk);
        #1;
        model(c, 1'b1, lz, s, a, ft);
        chk("seg_hex", 8'(seg_hex), 8'(s));
        chk("an_hex", 8'(an_hex), 8'(a));
        chk("ft_hex", 8'(ft_hex), 8'(ft));
        model(c, 1'b0, lz, s, a, ft);
        chk("seg_dec", 8'(seg_dec), 8'(s));
        chk("an_dec", 8'(an_dec), 8'(a));
        chk("ft_dec", 8'(ft_dec), 8'(ft));
        load = 1'b0;
        c++;
    endtask

    task automatic idle(input int n, input bit lz);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 4'h0, 4'h0, lz);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_seg_hex", 8'(seg_hex), 8'h7F);
        chk("rst_an_hex", 8'(an_hex), 8'h0F);
        chk("rst_ft_hex", 8'(ft_hex), 8'h00);
        chk("rst_seg_dec", 8'(seg_dec), 8'h7F);
        chk("rst_an_dec", 8'(an_dec), 8'h0F);
        chk("rst_ft_dec", 8'(ft_dec), 8'h00);
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  rbl;
        logic [3:0]  rbk;
        bit          rlz;
        n_cmp = 0; n_err = 0; c = 0;
        rst_n = 1'b1; load = 1'b0; lz_suppress = 1'b0;
        digits_in = '0; blank_mask = '0; blink_mask = '0;
        #2 rst_n = 1'b0;
        #20;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic scan of 1234.
        step(1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
        idle(40, 1'b0);
        // Leading-zero suppression, including an all-zero value.
        step(1'b1, 16'h0042, 4'h0, 4'h0, 1'b1);
        idle(24, 1'b1);
        step(1'b1, 16'h0000, 4'h0, 4'h0, 1'b1);
        idle(24, 1'b1);
        // Two loads inside one frame: only the later is ever shown.
        idle(5, 1'b0);
        step(1'b1, 16'h1111, 4'h0, 4'h0, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 16'h2222, 4'h0, 4'h0, 1'b0);
        idle(24, 1'b0);
        // Blink on digit 0.
        step(1'b1, 16'h5678, 4'h0, 4'b0001, 1'b0);
        idle(90, 1'b0);
        // Hex letters vs dash.
        step(1'b1, 16'hFACE, 4'h0, 4'h0, 1'b0);
        idle(24, 1'b0);
        // Load on the exact frame-boundary cycle.
        while ((c % FR) != FR - 1) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 16'h9081, 4'b0100, 4'h0, 1'b0);
        idle(20, 1'b0);

        // Random loads, masks and suppression.
        rlz = 1'b0;
        for (int i = 0; i < 320; i++) begin
            if (i % 50 == 0) rlz = ($urandom_range(0, 1) == 1);
            rd  = 16'($urandom);
            rd  = rd >> (4 * $urandom_range(0, 3));
            rbl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rbk = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            step($urandom_range(0, 7) == 0, rd, rbl, rbk, rlz);
        end

        // Reset dropped mid-scan must clear outputs without a clock edge.
        step(1'b1, 16'h8888, 4'h0, 4'h0, 1'b0);
        idle(21, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        loads.delete();
        idle(20, 1'b0);
        step(1'b1, 16'h3405, 4'h0, 4'h0, 1'b1);
        idle(36, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
